// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the fp_norm_round post-add stage.
// The top-level build option FP_ROUND_RNE_EN is consumed by fp_round_rne.
package fp_norm_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 28;
  localparam int FRAC_W    = 23;
  localparam int EXP_MAX   = 255;
  localparam int INT_EXP_W = 10;

  // Bit positions inside the extended mantissa
  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int GUARD_BIT  = 2;
  localparam int ROUND_BIT  = 1;
  localparam int STICKY_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Assemble a binary32 word from its fields
  function automatic logic [31:0] pack_fp(input logic              sign,
                                          input logic [EXP_W-1:0]  exp,
                                          input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational rounder: 24-bit significand plus guard/round/sticky.
// With FP_ROUND_RNE_EN defined it rounds to nearest even; otherwise it
// truncates. Inexact is reported in both builds.
module fp_round_rne (
  input  logic [23:0] sig,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  output logic [23:0] sig_rnd,
  output logic        carry,
  output logic        inexact
);

  logic inc;

  // Increment decision: ties go to the even significand
`ifdef FP_ROUND_RNE_EN
  assign inc = g & (r | s | sig[0]);
`else
  assign inc = 1'b0;
`endif

  // 25-bit add so the carry out of the significand is visible
  assign {carry, sig_rnd} = {1'b0, sig} + {24'd0, inc};
  assign inexact = g | r | s;

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalize and round stage for the binary32 adder.
// Iterative one-bit-per-cycle normalizer, single operation in flight.
// Rounding mode selected by FP_ROUND_RNE_EN (see fp_round_rne).
module fp_norm_round
  import fp_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  state_t                 state_reg, state_next;
  logic                   sign_reg, sign_next;
  logic [INT_EXP_W-1:0]   exp_reg, exp_next;
  logic [MANT_W-1:0]      mant_reg, mant_next;
  logic [31:0]            result_reg, result_next;
  logic                   ovf_reg, ovf_next;
  logic                   unf_reg, unf_next;
  logic                   inx_reg, inx_next;

  logic [23:0]            sig_rnd;
  logic                   rnd_carry;
  logic                   rnd_inexact;
  logic [INT_EXP_W-1:0]   exp_rnd;
  logic [FRAC_W-1:0]      frac_rnd;

  fp_round_rne u_round (
    .sig     (mant_reg[HIDDEN_BIT:GUARD_BIT+1]),
    .g       (mant_reg[GUARD_BIT]),
    .r       (mant_reg[ROUND_BIT]),
    .s       (mant_reg[STICKY_BIT]),
    .sig_rnd (sig_rnd),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  // A rounding carry means the significand became 2^24: shift right once
  assign exp_rnd  = exp_reg + {{(INT_EXP_W-1){1'b0}}, rnd_carry};
  assign frac_rnd = rnd_carry ? sig_rnd[23:1] : sig_rnd[22:0];

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      inx_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sign_reg   <= sign_next;
      exp_reg    <= exp_next;
      mant_reg   <= mant_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
      inx_reg    <= inx_next;
    end
  end

  // Next-state and datapath updates: one normalization step per NORM cycle
  always_comb begin
    state_next  = state_reg;
    sign_next   = sign_reg;
    exp_next    = exp_reg;
    mant_next   = mant_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    inx_next    = inx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next   = in_sign;
          exp_next    = {2'b00, in_exp};
          mant_next   = in_mant;
          result_next = '0;
          ovf_next    = 1'b0;
          unf_next    = 1'b0;
          inx_next    = 1'b0;
          state_next  = NORM;
        end
      end
      NORM: begin
        if (exp_reg == INT_EXP_W'(EXP_MAX)) begin
          // Inf/NaN: keep the payload untouched
          result_next = pack_fp(sign_reg, EXP_W'(EXP_MAX), mant_reg[HIDDEN_BIT-1:GUARD_BIT+1]);
          state_next  = OUT;
        end else if (mant_reg == '0) begin
          // Exact cancellation always yields +0
          result_next = '0;
          state_next  = OUT;
        end else if (mant_reg[CARRY_BIT]) begin
          mant_next  = {1'b0, mant_reg[CARRY_BIT:2], mant_reg[1] | mant_reg[0]};
          exp_next   = exp_reg + 1'b1;
          state_next = ROUND;
        end else if (mant_reg[HIDDEN_BIT]) begin
          state_next = ROUND;
        end else begin
          mant_next = {mant_reg[MANT_W-2:0], 1'b0};
          exp_next  = exp_reg - 1'b1;
          // Shifting from exp 1 (or below) lands at or under zero: flush
          if (exp_reg <= INT_EXP_W'(1)) begin
            result_next = {sign_reg, 31'd0};
            unf_next    = 1'b1;
            state_next  = OUT;
          end
        end
      end
      ROUND: begin
        inx_next = rnd_inexact;
        if (exp_rnd >= INT_EXP_W'(EXP_MAX)) begin
          result_next = pack_fp(sign_reg, EXP_W'(EXP_MAX), '0);
          ovf_next    = 1'b1;
        end else begin
          result_next = pack_fp(sign_reg, exp_rnd[EXP_W-1:0], frac_rnd);
        end
        state_next = OUT;
      end
      OUT: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready      = (state_reg == IDLE);
  assign out_valid     = (state_reg == OUT);
  assign out_result    = result_reg;
  assign out_overflow  = ovf_reg;
  assign out_underflow = unf_reg;
  assign out_inexact   = inx_reg;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: scoreboard of expected results,
// one task per scenario. Rounding expectations follow FP_ROUND_RNE_EN.
module tb_fp_norm_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  fp_norm_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for out_valid, counting edges after the accept edge
  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Pop the oldest expectation and compare against the visible output
  task automatic check_out(input int edges);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: output seen with no expectation");
      return;
    end
    e = sb_q.pop_front();
    if (!out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%0b after %0d edges, required 1", e.name, out_valid, edges);
      return;
    end
    $display("txn %s: result=%h ovf=%0b unf=%0b inx=%0b latency=%0d", e.name, out_result,
             out_overflow, out_underflow, out_inexact, edges);
    if (out_result !== e.res) begin
      errors++;
      $display("FAIL %s result: got %h, required %h", e.name, out_result, e.res);
    end
    checks++;
    if (out_overflow !== e.ovf) begin
      errors++;
      $display("FAIL %s overflow: got %0b, required %0b", e.name, out_overflow, e.ovf);
    end
    checks++;
    if (out_underflow !== e.unf) begin
      errors++;
      $display("FAIL %s underflow: got %0b, required %0b", e.name, out_underflow, e.unf);
    end
    checks++;
    if (out_inexact !== e.inx) begin
      errors++;
      $display("FAIL %s inexact: got %0b, required %0b", e.name, out_inexact, e.inx);
    end
    checks++;
    if (edges != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", e.name, edges, e.lat);
    end
  endtask

  // Drive one operand from IDLE, check its result, then drain with out_ready
  task automatic run_op(input logic s, input logic [7:0] ex, input logic [27:0] m,
                        input logic [31:0] res, input logic ovf, input logic unf,
                        input logic inx, input int lat, input string name);
    exp_t e;
    int edges;
    e.res = res; e.ovf = ovf; e.unf = unf; e.inx = inx; e.lat = lat; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before: got %0b, required 1", name, in_ready);
    end
    in_valid = 1'b1; in_sign = s; in_exp = ex; in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(edges);
    check_out(edges);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s drain: out_valid=%0b in_ready=%0b, required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 ||
        out_overflow !== 1'b0 || out_underflow !== 1'b0 || out_inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b result=%h flags=%0b%0b%0b, required 1 0 00000000 000",
               in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    run_op(1'b0, 8'd127, 28'h4000000, 32'h3F800000, 0, 0, 0, 2, "normal_one");
    run_op(1'b1, 8'd128, 28'h6000000, 32'hC0400000, 0, 0, 0, 2, "normal_neg");
  endtask

  task automatic test_carry();
    run_op(1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 0, 2, "carry");
    run_op(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1, 0, 0, 2, "carry_overflow");
    run_op(1'b0, 8'd127, 28'h8000001, 32'h40000000, 0, 0, 1, 2, "carry_sticky");
  endtask

  task automatic test_cancel();
    run_op(1'b0, 8'd130, 28'h0800000, 32'h3F800000, 0, 0, 0, 5, "cancel_3shift");
    run_op(1'b0, 8'd2,   28'h0100000, 32'h00000000, 0, 1, 0, 2, "flush_pos");
    run_op(1'b1, 8'd2,   28'h0100000, 32'h80000000, 0, 1, 0, 2, "flush_neg");
    run_op(1'b1, 8'd100, 28'h0000000, 32'h00000000, 0, 0, 0, 1, "zero");
  endtask

  task automatic test_passthrough();
    run_op(1'b1, 8'd255, 28'h4400008, 32'hFF880001, 0, 0, 0, 1, "nan_pass");
    run_op(1'b0, 8'd255, 28'h4000000, 32'h7F800000, 0, 0, 0, 1, "inf_pass");
  endtask

  task automatic test_round();
    run_op(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 1, 2, "round_tie_even");
`ifdef FP_ROUND_RNE_EN
    run_op(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 0, 0, 1, 2, "round_tie_odd");
    run_op(1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 1, 2, "round_carry_out");
`else
    run_op(1'b0, 8'd127, 28'h400000C, 32'h3F800001, 0, 0, 1, 2, "trunc_tie_odd");
    run_op(1'b0, 8'd127, 28'h7FFFFFC, 32'h3FFFFFFF, 0, 0, 1, 2, "trunc_all_ones");
`endif
  endtask

  // Backpressure for 4 cycles, then release and accept the next operand one cycle later
  task automatic test_back_to_back();
    exp_t e;
    int edges;
    logic [31:0] held;
    e.res = 32'h40000000; e.ovf = 1'b0; e.unf = 1'b0; e.inx = 1'b0; e.lat = 2; e.name = "bp_first";
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h8000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(edges);
    check_out(edges);
    held = out_result;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h40000000 ||
          out_overflow !== 1'b0 || out_inexact !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b result=%h (was %h), required 1 0 40000000",
                 i, out_valid, in_ready, out_result, held);
      end
    end
    e.res = 32'h3F800000; e.ovf = 1'b0; e.unf = 1'b0; e.inx = 1'b0; e.lat = 2; e.name = "bp_second";
    sb_q.push_back(e);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h4000000;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%0b, required 0", in_ready);
    end
    wait_out(edges);
    check_out(edges);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reset during the normalization shifts, then a fresh operand
  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd130; in_mant = 28'h0800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%0b in_ready=%0b result=%h, required 0 1 00000000",
               out_valid, in_ready, out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'd130, 28'h0800000, 32'h3F800000, 0, 0, 0, 5, "after_reset");
  endtask

  initial begin
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 28'd0;
    out_ready = 1'b0;
    test_reset();
    test_normal();
    test_carry();
    test_cancel();
    test_passthrough();
    test_round();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
